// File: rtl/zorro_autoconfig_master.sv
// ---------------------------------------------------------------------------
// zorro_autoconfig_master
// Host-side Zorro II AutoConfig initiator. It walks the CFGIN/CFGOUT chain at
// $E80000 over a 68000-style AS/UDS/DTACK bus. For each board it reads the
// nibble-wide config registers and places the board at a size-aligned base
// taken from a memory or I/O pool. A board that cannot be placed is shut up.
//
// Ports:
//   CLK, RESET_n      clock, asynchronous active-low reset
//   start             one-cycle pulse; begins a scan when idle
//   ADDR[22:0]        bus address A23..A1
//   AS_n, UDS_n, RW   bus strobes and direction (RW=1 read)
//   DOUT, DOE         write nibble on D15..D12 and its output enable
//   DIN, DTACK_n      read nibble on D15..D12 and data acknowledge
//   busy, done, error scan status (done is a one-clock pulse; error is sticky)
//   board_count       boards configured in this scan
//   last_mfg/prod/base  identity and base of the last configured board
//
// Optional build macro AUTOCONFIG_LOG_EN adds log_we/log_data, a per-board
// record {shutup, memlist, mfg, prod, base}.
// ---------------------------------------------------------------------------
module zorro_autoconfig_master #(
    parameter int         DTACK_TIMEOUT = 64,
    parameter int         MAX_BOARDS    = 8,
    parameter logic [7:0] MEM_LO        = 8'h20,
    parameter logic [7:0] MEM_HI        = 8'hA0,
    parameter logic [7:0] IO_LO         = 8'hE9,
    parameter logic [7:0] IO_HI         = 8'hF0
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        start,
    output logic [22:0] ADDR,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        RW,
    output logic [3:0]  DOUT,
    output logic        DOE,
    input  logic [3:0]  DIN,
    input  logic        DTACK_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  board_count,
    output logic [15:0] last_mfg,
    output logic [7:0]  last_prod,
    output logic [7:0]  last_base
`ifdef AUTOCONFIG_LOG_EN
    ,
    output logic        log_we,
    output logic [33:0] log_data
`endif
);

    localparam int            TW       = $clog2(DTACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(DTACK_TIMEOUT - 1);
    localparam logic [7:0]    CFG_A23  = 8'hE8;

    typedef enum logic [2:0] {
        S_IDLE, S_READ_REGS, S_ALLOC, S_WR_LO, S_WR_HI, S_WR_SHUTUP, S_NEXT, S_DONE
    } state_t;

    // WAIT holds off a new access until DTACK_n has been released.
    typedef enum logic [1:0] {PH_WAIT, PH_SETUP, PH_STROBE, PH_END} phase_t;

    // Board size in 64K units from the 3-bit size code.
    function automatic logic [8:0] size_units(input logic [2:0] code);
        logic [8:0] units;
        case (code)
            3'b001:  units = 9'd1;
            3'b010:  units = 9'd2;
            3'b011:  units = 9'd4;
            3'b100:  units = 9'd8;
            3'b101:  units = 9'd16;
            3'b110:  units = 9'd32;
            3'b111:  units = 9'd64;
            default: units = 9'd128;
        endcase
        return units;
    endfunction

    state_t        state_r, state_s;
    phase_t        phase_r, phase_s;
    logic [2:0]    idx_r, idx_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          to_r, to_s;
    logic [1:0]    er_r, er_s;
    logic          memlist_r, memlist_s;
    logic [2:0]    size_code_r, size_code_s;
    logic [7:0]    prod_r, prod_s;
    logic [15:0]   mfg_r, mfg_s;
    logic [7:0]    cand_r, cand_s;
    logic [7:0]    mem_ptr_r, mem_ptr_s, io_ptr_r, io_ptr_s;
    logic [22:0]   addr_s;
    logic          as_n_s, uds_n_s, rw_s, doe_s, busy_s, done_s, error_s;
    logic [3:0]    dout_s, board_count_s;
    logic [15:0]   last_mfg_s;
    logic [7:0]    last_prod_s, last_base_s;
`ifdef AUTOCONFIG_LOG_EN
    logic          log_we_s;
    logic [33:0]   log_data_s;
`endif

    logic [7:0] acc_reg_s;
    logic       acc_rw_s;
    logic [3:0] acc_dout_s;
    logic [7:0] pool_ptr_s, pool_hi_s;
    logic [8:0] size_s, mask_s, cand9_s, end9_s;

    // Register index, direction and write nibble of the access owned by the current state.
    always_comb begin
        acc_reg_s  = 8'h00;
        acc_rw_s   = 1'b1;
        acc_dout_s = 4'h0;
        case (state_r)
            S_READ_REGS: acc_reg_s = {4'h0, idx_r[2], 1'b0, idx_r[1:0]};
            S_WR_LO: begin
                acc_reg_s  = 8'h25;
                acc_rw_s   = 1'b0;
                acc_dout_s = cand_r[3:0];
            end
            S_WR_HI: begin
                acc_reg_s  = 8'h24;
                acc_rw_s   = 1'b0;
                acc_dout_s = cand_r[7:4];
            end
            S_WR_SHUTUP: begin
                acc_reg_s  = 8'h26;
                acc_rw_s   = 1'b0;
            end
            default: acc_reg_s = 8'h00;
        endcase
    end

    // Size-aligned candidate base, kept 9 bits wide so running past $FF is visible.
    always_comb begin
        pool_ptr_s = memlist_r ? mem_ptr_r : io_ptr_r;
        pool_hi_s  = memlist_r ? MEM_HI : IO_HI;
        size_s     = size_units(size_code_r);
        mask_s     = size_s - 9'd1;
        cand9_s    = ({1'b0, pool_ptr_s} + mask_s) & ~mask_s;
        end9_s     = cand9_s + size_s;
    end

    // Next-state and next-output logic for the scan and bus-cycle sequencers.
    always_comb begin
        state_s       = state_r;
        phase_s       = phase_r;
        idx_s         = idx_r;
        tmo_s         = tmo_r;
        to_s          = to_r;
        er_s          = er_r;
        memlist_s     = memlist_r;
        size_code_s   = size_code_r;
        prod_s        = prod_r;
        mfg_s         = mfg_r;
        cand_s        = cand_r;
        mem_ptr_s     = mem_ptr_r;
        io_ptr_s      = io_ptr_r;
        addr_s        = ADDR;
        as_n_s        = AS_n;
        uds_n_s       = UDS_n;
        rw_s          = RW;
        dout_s        = DOUT;
        doe_s         = DOE;
        busy_s        = busy;
        done_s        = 1'b0;
        error_s       = error;
        board_count_s = board_count;
        last_mfg_s    = last_mfg;
        last_prod_s   = last_prod;
        last_base_s   = last_base;
`ifdef AUTOCONFIG_LOG_EN
        log_we_s      = 1'b0;
        log_data_s    = log_data;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_s        = 1'b1;
                    error_s       = 1'b0;
                    board_count_s = 4'd0;
                    mem_ptr_s     = MEM_LO;
                    io_ptr_s      = IO_LO;
                    idx_s         = 3'd0;
                    phase_s       = PH_WAIT;
                    state_s       = S_READ_REGS;
                end else begin
                    busy_s        = 1'b0;
                end
            end
            S_READ_REGS, S_WR_LO, S_WR_HI, S_WR_SHUTUP: begin
                case (phase_r)
                    PH_WAIT: begin
                        if (DTACK_n) begin
                            addr_s  = {CFG_A23, 7'h00, acc_reg_s};
                            rw_s    = acc_rw_s;
                            dout_s  = acc_dout_s;
                            doe_s   = ~acc_rw_s;
                            phase_s = PH_SETUP;
                        end else begin
                            phase_s = PH_WAIT;
                        end
                    end
                    PH_SETUP: begin
                        as_n_s  = 1'b0;
                        uds_n_s = 1'b0;
                        tmo_s   = '0;
                        to_s    = 1'b0;
                        phase_s = PH_STROBE;
                    end
                    PH_STROBE: begin
                        if (!DTACK_n) begin
                            as_n_s  = 1'b1;
                            uds_n_s = 1'b1;
                            phase_s = PH_END;
                            if (state_r == S_READ_REGS) begin
                                // Only reg00/reg01 arrive true; the rest are inverted on the bus.
                                case (idx_r)
                                    3'd0: begin
                                        er_s      = DIN[3:2];
                                        memlist_s = DIN[1];
                                    end
                                    3'd1:    size_code_s   = DIN[2:0];
                                    3'd2:    prod_s[7:4]   = ~DIN;
                                    3'd3:    prod_s[3:0]   = ~DIN;
                                    3'd4:    mfg_s[15:12]  = ~DIN;
                                    3'd5:    mfg_s[11:8]   = ~DIN;
                                    3'd6:    mfg_s[7:4]    = ~DIN;
                                    default: mfg_s[3:0]    = ~DIN;
                                endcase
                            end else begin
                                er_s = er_r;
                            end
                        end else if (tmo_r == TMO_LAST) begin
                            as_n_s  = 1'b1;
                            uds_n_s = 1'b1;
                            to_s    = 1'b1;
                            phase_s = PH_END;
                        end else begin
                            tmo_s   = tmo_r + TW'(1);
                        end
                    end
                    default: begin
                        // END: strobes already high, address still held this clock.
                        rw_s    = 1'b1;
                        doe_s   = 1'b0;
                        dout_s  = 4'h0;
                        phase_s = PH_WAIT;
                        if (to_r) begin
                            // A silent reg00 means the chain is empty, not a fault.
                            if (!(state_r == S_READ_REGS && idx_r == 3'd0)) begin
                                error_s = 1'b1;
                            end else begin
                                error_s = error;
                            end
                            state_s = S_DONE;
                        end else begin
                            case (state_r)
                                S_READ_REGS: begin
                                    if (idx_r == 3'd7) begin
                                        state_s = S_ALLOC;
                                    end else begin
                                        idx_s = idx_r + 3'd1;
                                    end
                                end
                                S_WR_LO: state_s = S_WR_HI;
                                S_WR_HI: begin
                                    last_mfg_s    = mfg_r;
                                    last_prod_s   = prod_r;
                                    last_base_s   = cand_r;
                                    board_count_s = board_count + 4'd1;
`ifdef AUTOCONFIG_LOG_EN
                                    log_we_s      = 1'b1;
                                    log_data_s    = {1'b0, memlist_r, mfg_r, prod_r, cand_r};
`endif
                                    state_s       = S_NEXT;
                                end
                                default: begin
`ifdef AUTOCONFIG_LOG_EN
                                    log_we_s   = 1'b1;
                                    log_data_s = {1'b1, memlist_r, mfg_r, prod_r, 8'h00};
`endif
                                    state_s    = S_NEXT;
                                end
                            endcase
                        end
                    end
                endcase
            end
            S_ALLOC: begin
                phase_s = PH_WAIT;
                if (er_r != 2'b11 || end9_s > {1'b0, pool_hi_s}) begin
                    state_s = S_WR_SHUTUP;
                end else begin
                    cand_s = cand9_s[7:0];
                    if (memlist_r) begin
                        mem_ptr_s = end9_s[7:0];
                    end else begin
                        io_ptr_s = end9_s[7:0];
                    end
                    state_s = S_WR_LO;
                end
            end
            S_NEXT: begin
                if (board_count == 4'(MAX_BOARDS)) begin
                    state_s = S_DONE;
                end else begin
                    idx_s   = 3'd0;
                    phase_s = PH_WAIT;
                    state_s = S_READ_REGS;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State and output registers; reset drives the strobes high immediately.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r     <= S_IDLE;
            phase_r     <= PH_WAIT;
            idx_r       <= 3'd0;
            tmo_r       <= '0;
            to_r        <= 1'b0;
            er_r        <= 2'b00;
            memlist_r   <= 1'b0;
            size_code_r <= 3'd0;
            prod_r      <= 8'h00;
            mfg_r       <= 16'h0000;
            cand_r      <= 8'h00;
            mem_ptr_r   <= MEM_LO;
            io_ptr_r    <= IO_LO;
            ADDR        <= 23'h000000;
            AS_n        <= 1'b1;
            UDS_n       <= 1'b1;
            RW          <= 1'b1;
            DOUT        <= 4'h0;
            DOE         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            board_count <= 4'd0;
            last_mfg    <= 16'h0000;
            last_prod   <= 8'h00;
            last_base   <= 8'h00;
`ifdef AUTOCONFIG_LOG_EN
            log_we      <= 1'b0;
            log_data    <= 34'h0;
`endif
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            idx_r       <= idx_s;
            tmo_r       <= tmo_s;
            to_r        <= to_s;
            er_r        <= er_s;
            memlist_r   <= memlist_s;
            size_code_r <= size_code_s;
            prod_r      <= prod_s;
            mfg_r       <= mfg_s;
            cand_r      <= cand_s;
            mem_ptr_r   <= mem_ptr_s;
            io_ptr_r    <= io_ptr_s;
            ADDR        <= addr_s;
            AS_n        <= as_n_s;
            UDS_n       <= uds_n_s;
            RW          <= rw_s;
            DOUT        <= dout_s;
            DOE         <= doe_s;
            busy        <= busy_s;
            done        <= done_s;
            error       <= error_s;
            board_count <= board_count_s;
            last_mfg    <= last_mfg_s;
            last_prod   <= last_prod_s;
            last_base   <= last_base_s;
`ifdef AUTOCONFIG_LOG_EN
            log_we      <= log_we_s;
            log_data    <= log_data_s;
`endif
        end
    end

endmodule

// File: tb/tb_zorro_autoconfig_master.sv
// ---------------------------------------------------------------------------
// tb_zorro_autoconfig_master
// Directed bench for zorro_autoconfig_master. A behavioural board chain
// answers bus cycles at the negative clock edge and records every write;
// expected writes and per-scan summaries are queued with the stimulus and
// popped when the scan finishes.
// ---------------------------------------------------------------------------
module tb_zorro_autoconfig_master;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  DIN = 4'h0;
    logic        DTACK_n = 1'b1;
    logic [22:0] ADDR;
    logic        AS_n, UDS_n, RW, DOE, busy, done, error;
    logic [3:0]  DOUT, board_count;
    logic [15:0] last_mfg;
    logic [7:0]  last_prod, last_base;

    zorro_autoconfig_master dut (
        .CLK(CLK), .RESET_n(RESET_n), .start(start), .ADDR(ADDR), .AS_n(AS_n),
        .UDS_n(UDS_n), .RW(RW), .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .DTACK_n(DTACK_n),
        .busy(busy), .done(done), .error(error), .board_count(board_count),
        .last_mfg(last_mfg), .last_prod(last_prod), .last_base(last_base)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  r00;
        logic [3:0]  r01;
        logic [7:0]  prod;
        logic [15:0] mfg;
        logic        stall08;
    } board_t;

    typedef struct packed {
        logic [3:0]  cnt;
        logic        err;
        logic [7:0]  base;
        logic [15:0] mfg;
        logic [7:0]  prod;
    } summ_t;

    board_t      board_q[$];
    logic [11:0] exp_wr_q[$];
    logic [11:0] obs_wr_q[$];
    summ_t       exp_sum_q[$];
    int          errors = 0;
    int          checks = 0;
    int          strobes = 0;
    logic        acked = 1'b0;
    logic        as_prev = 1'b1;
    logic [7:0]  rsp_reg;

    function automatic logic [3:0] bus_nibble(input board_t b, input logic [7:0] r);
        case (r)
            8'h00:   return b.r00;
            8'h01:   return b.r01;
            8'h02:   return ~b.prod[7:4];
            8'h03:   return ~b.prod[3:0];
            8'h08:   return ~b.mfg[15:12];
            8'h09:   return ~b.mfg[11:8];
            8'h0A:   return ~b.mfg[7:4];
            8'h0B:   return ~b.mfg[3:0];
            default: return 4'hF;
        endcase
    endfunction

    // Board chain model: head board answers; a write to $48 or $4C passes CFGOUT on.
    always @(negedge CLK) begin
        if (as_prev && !AS_n) strobes = strobes + 1;
        as_prev = AS_n;
        if (AS_n) begin
            DTACK_n = 1'b1;
            acked   = 1'b0;
        end else if (!acked && board_q.size() > 0 && ADDR[22:15] == 8'hE8) begin
            rsp_reg = ADDR[7:0];
            if (!(board_q[0].stall08 && rsp_reg == 8'h08)) begin
                DTACK_n = 1'b0;
                acked   = 1'b1;
                if (RW) begin
                    DIN = bus_nibble(board_q[0], rsp_reg);
                end else begin
                    obs_wr_q.push_back({rsp_reg, DOUT});
                    if (rsp_reg == 8'h24 || rsp_reg == 8'h26) void'(board_q.pop_front());
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_board(input logic [3:0] r00, input logic [3:0] r01, input logic [7:0] prod,
                             input logic [15:0] mfg, input logic stall08);
        board_t b;
        b = '{r00: r00, r01: r01, prod: prod, mfg: mfg, stall08: stall08};
        board_q.push_back(b);
    endtask

    task automatic expect_wr(input logic [7:0] r, input logic [3:0] nib);
        exp_wr_q.push_back({r, nib});
    endtask

    task automatic expect_sum(input logic [3:0] cnt, input logic err, input logic [7:0] base,
                              input logic [15:0] mfg, input logic [7:0] prod);
        summ_t s;
        s = '{cnt: cnt, err: err, base: base, mfg: mfg, prod: prod};
        exp_sum_q.push_back(s);
    endtask

    // Pulse start, wait (bounded) for done, then pop and compare the scoreboards.
    task automatic run_scan(input string tag);
        logic  seen;
        summ_t s;
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_as_n"}, AS_n, 1'b1);
        if (exp_sum_q.size() > 0) begin
            s = exp_sum_q.pop_front();
            check({tag, "_count"}, board_count, s.cnt);
            check({tag, "_error"}, error, s.err);
            check({tag, "_base"}, last_base, s.base);
            check({tag, "_mfg"}, last_mfg, s.mfg);
            check({tag, "_prod"}, last_prod, s.prod);
        end
        check({tag, "_nwr"}, obs_wr_q.size(), exp_wr_q.size());
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0)
            check({tag, "_wr"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
        exp_wr_q.delete();
        obs_wr_q.delete();
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int   s0;
        logic seen;

        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_addr", ADDR, 23'h0);
        check("rst_as_n", AS_n, 1'b1);
        check("rst_uds_n", UDS_n, 1'b1);
        check("rst_rw", RW, 1'b1);
        check("rst_doe", DOE, 1'b0);
        check("rst_dout", DOUT, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_count", board_count, 4'd0);
        check("rst_last", {last_mfg, last_prod, last_base}, 32'h0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Empty chain: one reg00 strobe, then timeout without error.
        s0 = strobes;
        expect_sum(4'd0, 1'b0, 8'h00, 16'h0000, 8'h00);
        run_scan("empty");
        check("empty_strobes", strobes - s0, 1);

        // One 128K I/O board.
        add_board(4'b1101, 4'b0010, 8'h05, 16'h144A, 1'b0);
        expect_wr(8'h25, 4'hA); expect_wr(8'h24, 4'hE);
        expect_sum(4'd1, 1'b0, 8'hEA, 16'h144A, 8'h05);
        run_scan("one_io");

        // Two 128K I/O boards.
        add_board(4'b1101, 4'b0010, 8'h22, 16'h1111, 1'b0);
        add_board(4'b1101, 4'b0010, 8'h44, 16'h3333, 1'b0);
        expect_wr(8'h25, 4'hA); expect_wr(8'h24, 4'hE);
        expect_wr(8'h25, 4'hC); expect_wr(8'h24, 4'hE);
        expect_sum(4'd2, 1'b0, 8'hEC, 16'h3333, 8'h44);
        run_scan("two_io");

        // 8MB memory board cannot fit; the following board is still configured.
        add_board(4'b1110, 4'b0000, 8'h10, 16'h0AAA, 1'b0);
        add_board(4'b1101, 4'b0001, 8'h77, 16'h2017, 1'b0);
        expect_wr(8'h26, 4'h0);
        expect_wr(8'h25, 4'h9); expect_wr(8'h24, 4'hE);
        expect_sum(4'd1, 1'b0, 8'hE9, 16'h2017, 8'h77);
        run_scan("mem8m");

        // I/O pool edge: ending exactly at IO_HI fits, the next one does not.
        add_board(4'b1101, 4'b0011, 8'h01, 16'h0101, 1'b0);
        add_board(4'b1101, 4'b0011, 8'h02, 16'h0202, 1'b0);
        expect_wr(8'h25, 4'hC); expect_wr(8'h24, 4'hE);
        expect_wr(8'h26, 4'h0);
        expect_sum(4'd1, 1'b0, 8'hEC, 16'h0101, 8'h01);
        run_scan("io_edge");

        // Second board stalls on reg08: error set, count keeps the first board.
        add_board(4'b1101, 4'b0001, 8'h09, 16'h0999, 1'b0);
        add_board(4'b1101, 4'b0001, 8'h0B, 16'h0BBB, 1'b1);
        expect_wr(8'h25, 4'h9); expect_wr(8'h24, 4'hE);
        expect_sum(4'd1, 1'b1, 8'hE9, 16'h0999, 8'h09);
        run_scan("tmo08");
        board_q.delete();

        // Next start clears error; last_* keep the previous board.
        expect_sum(4'd0, 1'b0, 8'hE9, 16'h0999, 8'h09);
        run_scan("clr_err");

        // MAX_BOARDS stops the scan with a ninth board still waiting.
        for (int i = 0; i < 9; i++) begin
            add_board(4'b1110, 4'b0001, 8'(i), 16'h4000 + 16'(i), 1'b0);
            if (i < 8) begin
                expect_wr(8'h25, 4'(i));
                expect_wr(8'h24, 4'h2);
            end
        end
        expect_sum(4'd8, 1'b0, 8'h27, 16'h4007, 8'h07);
        run_scan("max");
        check("max_left", board_q.size(), 1);
        board_q.delete();

        // Reset while AS_n is low forces the strobes high before the next edge.
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge CLK);
            if (!AS_n) seen = 1'b1;
        end
        check("mid_as_low", seen, 1'b1);
        #2 RESET_n = 1'b0;
        #1;
        check("mid_as_n", AS_n, 1'b1);
        check("mid_uds_n", UDS_n, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_addr", ADDR, 23'h0);
        check("mid_last", {last_mfg, last_prod, last_base}, 32'h0);
        @(negedge CLK) RESET_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_busy", busy, 1'b0);
        check("post_as_n", AS_n, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zorro_autoconfig_master.md
Name: zorro_autoconfig_master

Overview:
Host-side Zorro II AutoConfig initiator that walks the CFGIN/CFGOUT chain at $E80000. It reads each board's nibble-wide config registers, allocates a size-aligned base from a memory or I/O pool, and writes the base back; a board that cannot be placed is shut up. It is used in bench environments and on host-side boards that must configure downstream Zorro II cards, and it drives a 68000-style AS/UDS/DTACK bus.

Parameters:
DTACK_TIMEOUT, 64, clocks to wait for DTACK_n before a bus timeout
MAX_BOARDS, 8, maximum boards configured per scan
MEM_LO, 8'h20, first 64K unit of the memory pool (A23..A16)
MEM_HI, 8'hA0, exclusive end of the memory pool
IO_LO, 8'hE9, first 64K unit of the I/O pool
IO_HI, 8'hF0, exclusive end of the I/O pool

Ports:
CLK  in  1  system clock
RESET_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a scan when idle
ADDR  out  23  bus address A23..A1
AS_n  out  1  address strobe
UDS_n  out  1  upper data strobe
RW  out  1  1=read, 0=write
DOUT  out  4  write nibble, driven on D15..D12
DOE  out  1  data output enable; high only during write strobes
DIN  in  4  read nibble from D15..D12
DTACK_n  in  1  data acknowledge
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end
error  out  1  sticky until next start; timeout mid-board
board_count  out  4  boards successfully configured
last_mfg  out  16  manufacturer ID of last configured board
last_prod  out  8  product ID of last configured board
last_base  out  8  A23..A16 assigned to last configured board

Behaviour:
- Reset values: ADDR=0, AS_n=1, UDS_n=1, RW=1, DOUT=0, DOE=0, busy=0, done=0, error=0, board_count=0, last_*=0. Pool pointers reset to MEM_LO and IO_LO.
- Bus cycle, fixed for every access:
  - SETUP (1 clk): ADDR and RW valid; DOUT and DOE valid for writes.
  - STROBE: AS_n=UDS_n=0. Hold until DTACK_n is sampled low, with a timeout counter of DTACK_TIMEOUT clocks.
  - On DTACK_n low: DIN is latched at that edge.
  - END (1 clk): AS_n=UDS_n=1 while ADDR is still held. This gives every access a rising AS_n, which responders use to advance the chain.
- States: IDLE -> READ_REGS -> ALLOC -> WR_LO -> WR_HI -> NEXT, or ALLOC -> WR_SHUTUP -> NEXT. NEXT -> READ_REGS or DONE.
- start: ignored unless in IDLE. On accept, busy=1, error=0, board_count=0, and pools are reinitialised.
- READ_REGS: reads ADDR[8:1]=00,01,02,03,08,09,0A,0B in that order.
  - Nibbles 00 and 01 are used raw. All other nibbles are inverted before use.
  - reg00[3:2] is ER_Type (must be 2'b11); reg00[1] is MEMLIST.
  - reg01[2:0] is the size code. Size in 64K units: 001=1, 010=2, 011=4, 100=8, 101=16, 110=32, 111=64, 000=128.
  - prod = {~r02, ~r03}; mfg = {~r08, ~r09, ~r0A, ~r0B}.
- Timeout on the reg00 read: the chain is empty. Go to DONE with error unchanged.
- Timeout on any other access: set error=1 and go to DONE.
- ALLOC:
  - Pool is memory if MEMLIST=1, else I/O.
  - cand = pool pointer rounded up to a multiple of size, computed in 9 bits so overflow is visible.
  - If ER_Type != 2'b11, or cand+size > pool_HI: go to WR_SHUTUP.
  - Otherwise pointer <= cand+size and go to WR_LO.
- WR_LO: write cand[3:0] to ADDR[8:1]=0x25 ($4A).
- WR_HI: write cand[7:4] to 0x24 ($48). This configures the board. Then last_mfg/last_prod/last_base update and board_count increments.
- WR_SHUTUP: write 4'h0 to 0x26 ($4C). board_count does not increment.
- NEXT: if board_count == MAX_BOARDS, go to DONE; else return to READ_REGS.
- DONE: done=1 for exactly one clock, busy=0, return to IDLE.
- DTACK_n held low across END: no new access until DTACK_n is sampled high again.
- A reset mid-cycle forces AS_n and UDS_n high immediately (asynchronous).

Optional Feature:
AUTOCONFIG_LOG_EN
- Defined: adds log_we (out, 1) and log_data (out, 34) = {shutup_flag, memlist, mfg[15:0], prod[7:0], base[7:0]}. log_we pulses one clock after the final write for every board, whether configured or shut up. base=0 when shut up.
- Undefined: the ports are absent and only the last_* summary exists.

Test Plan:
- No responder (DTACK_n stuck high), start -> 8 reads of 00? No: one reg00 read, then timeout after 64 clocks -> done pulse, board_count=0, error=0.
- One I/O board with reg00=4'b1101, reg01=4'b0010, mfg 0x144A, prod 0x05 -> writes $4A=4'hA then $48=4'hE; last_base=8'hEA, last_mfg=16'h144A, last_prod=8'h05, board_count=1.
- Two I/O boards of 128K each -> bases 8'hEA then 8'hEC; board_count=2.
- Memory board with size code 000 (8MB) -> cannot fit (aligned base 8'h80+128 > 8'hA0) -> write to $4C, board_count=0, next board still scanned.
- DTACK timeout on the reg08 read -> error=1, done pulses, AS_n high, board_count unchanged.
- RESET_n asserted while AS_n=0 -> AS_n and UDS_n high within the same clock, all outputs at reset values, busy=0.
